// File: rtl/fwd_pkg.sv
// fwd_pkg: forward select encodings and pipeline shadow record types
package fwd_pkg;
    localparam int REG_W = 5;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dst;
        logic             rw;
        logic             mr;
    } ex_rec_t;
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dst;
        logic             rw;
        logic             mr;
    } mem_rec_t;
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dst;
        logic             rw;
    } wb_rec_t;
    function automatic logic writes(input wb_rec_t w, input logic [REG_W-1:0] r);
        return w.v & w.rw & (w.dst != '0) & (w.dst == r);
    endfunction
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage hazard inputs and forwarding/stall outputs
interface fwd_hazard_ctrl_if
    import fwd_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic             mem_freeze;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall_if_id;
    logic             bubble_ex;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst, id_regwrite, id_memread,
        output flush, mem_freeze,
        input  forward_a, forward_b, stall_if_id, bubble_ex, stall_cnt
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst, id_regwrite, id_memread,
        input  flush, mem_freeze,
        output forward_a, forward_b, stall_if_id, bubble_ex, stall_cnt
    );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: picks the operand source for one EX register, newest writer first
module fwd_select
    import fwd_pkg::*;
(
    input  logic             en,
    input  logic [REG_W-1:0] src,
    input  wb_rec_t          mem,
    input  wb_rec_t          wb,
    output logic [1:0]       sel
);
    always_comb sel = !en ? FWD_RF : writes(mem, src) ? FWD_MEM : writes(wb, src) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding, load-use stall and stall-cycle counter
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_ctrl_if.slave   bus
);
    ex_rec_t          ex_q, ex_d;
    mem_rec_t         mem_q, mem_d;
    wb_rec_t          wb_q, wb_d;
    wb_rec_t          mem_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             bubble;
    always_comb begin
        mem_w  = '{v: mem_q.v, dst: mem_q.dst, rw: mem_q.rw};
        lu     = bus.id_valid & ex_q.v & ex_q.mr & ex_q.rw & (ex_q.dst != '0)
               & ((bus.id_uses_rs & (bus.id_rs == ex_q.dst)) | (bus.id_uses_rt & (bus.id_rt == ex_q.dst)));
        bubble = ~bus.mem_freeze & (bus.flush | lu);
        ex_d   = bus.mem_freeze ? ex_q : bubble ? '0
               : ex_rec_t'{bus.id_valid, bus.id_rs, bus.id_rt, bus.id_dst, bus.id_regwrite, bus.id_memread};
        mem_d  = bus.mem_freeze ? mem_q : mem_rec_t'{ex_q.v, ex_q.dst, ex_q.rw, ex_q.mr};
        wb_d   = bus.mem_freeze ? wb_q : mem_w;
        cnt_d  = (lu & ~bus.flush & ~bus.mem_freeze & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end
    fwd_select u_sel_a (.en(ex_q.v), .src(ex_q.rs), .mem(mem_w), .wb(wb_q), .sel(bus.forward_a));
    fwd_select u_sel_b (.en(ex_q.v), .src(ex_q.rt), .mem(mem_w), .wb(wb_q), .sel(bus.forward_b));
    // flush is a raw input, so the bubble must be masked while reset is held
    assign bus.bubble_ex   = rst_n & bubble;
    assign bus.stall_if_id = ~bus.mem_freeze & ~bus.flush & lu;
    assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: scoreboard bench against a pipeline model, plus a 2-bit counter instance
module tb_fwd_hazard_ctrl;
    import fwd_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fwd_hazard_ctrl_if #(.CNT_W(16)) ifm ();
    fwd_hazard_ctrl_if #(.CNT_W(2))  ifs ();
    assign ifs.id_valid    = ifm.id_valid;
    assign ifs.id_rs       = ifm.id_rs;
    assign ifs.id_rt       = ifm.id_rt;
    assign ifs.id_uses_rs  = ifm.id_uses_rs;
    assign ifs.id_uses_rt  = ifm.id_uses_rt;
    assign ifs.id_dst      = ifm.id_dst;
    assign ifs.id_regwrite = ifm.id_regwrite;
    assign ifs.id_memread  = ifm.id_memread;
    assign ifs.flush       = ifm.flush;
    assign ifs.mem_freeze  = ifm.mem_freeze;
    fwd_hazard_ctrl #(.CNT_W(16)) dut     (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
    fwd_hazard_ctrl #(.CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));
    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt, dst;
        logic       urs, urt, rw, mr;
    } ins_t;
    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        st, bu;
        logic [15:0] c;
        logic [1:0]  c2;
    } exp_t;
    ins_t m_ex, m_mem, m_wb;
    int   m_cnt = 0;
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic last_hold = 1'b0;
    function automatic ins_t alu(input logic [4:0] d, s, t);
        return '{1'b1, s, t, d, 1'b1, 1'b1, 1'b1, 1'b0};
    endfunction
    function automatic ins_t lw(input logic [4:0] d, s);
        return '{1'b1, s, 5'd0, d, 1'b1, 1'b0, 1'b1, 1'b1};
    endfunction
    function automatic logic wr(input ins_t r, input logic [4:0] x);
        return r.v && r.rw && r.dst != 0 && r.dst == x;
    endfunction
    function automatic logic [1:0] m_sel(input logic [4:0] x);
        if (!m_ex.v) return 2'b00;
        if (wr(m_mem, x)) return 2'b10;
        if (wr(m_wb, x)) return 2'b01;
        return 2'b00;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input ins_t i, input logic fl = 1'b0, input logic fz = 1'b0);
        exp_t e, g;
        logic lu, viol;
        @(negedge clk);
        ifm.id_valid = i.v; ifm.id_rs = i.rs; ifm.id_rt = i.rt; ifm.id_dst = i.dst;
        ifm.id_uses_rs = i.urs; ifm.id_uses_rt = i.urt; ifm.id_regwrite = i.rw; ifm.id_memread = i.mr;
        ifm.flush = fl; ifm.mem_freeze = fz;
        lu = i.v && m_ex.v && m_ex.mr && m_ex.rw && m_ex.dst != 0
             && ((i.urs && i.rs == m_ex.dst) || (i.urt && i.rt == m_ex.dst));
        e.fa = m_sel(m_ex.rs);
        e.fb = m_sel(m_ex.rt);
        e.st = !fz && !fl && lu;
        e.bu = !fz && (fl || lu);
        e.c  = 16'(m_cnt);
        e.c2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        exp_q.push_back(e);
        #2;
        g = exp_q.pop_front();
        chk("forward_a", 32'(ifm.forward_a), 32'(g.fa));
        chk("forward_b", 32'(ifm.forward_b), 32'(g.fb));
        chk("stall_if_id", 32'(ifm.stall_if_id), 32'(g.st));
        chk("bubble_ex", 32'(ifm.bubble_ex), 32'(g.bu));
        chk("stall_cnt", 32'(ifm.stall_cnt), 32'(g.c));
        chk("stall_cnt_w2", 32'(ifs.stall_cnt), 32'(g.c2));
        viol = m_mem.v && m_mem.mr && m_mem.dst != 0 && m_ex.v
               && ((m_ex.urs && m_ex.rs == m_mem.dst) || (m_ex.urt && m_ex.rt == m_mem.dst));
        chk("load_in_mem_invariant", 32'(viol), 32'd0);
        last_hold = e.st || fz;
        if (!fz) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = e.bu ? '0 : i;
            if (lu && !fl) m_cnt++;
        end
    endtask
    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
        exp_q.delete();
    endtask
    initial begin
        ins_t cur, nop;
        nop = '0;
        model_reset();
        ifm.id_valid = 0; ifm.id_rs = 0; ifm.id_rt = 0; ifm.id_dst = 0; ifm.id_uses_rs = 0;
        ifm.id_uses_rt = 0; ifm.id_regwrite = 0; ifm.id_memread = 0; ifm.flush = 1'b1; ifm.mem_freeze = 0;
        #1;
        chk("rst_forward_a", 32'(ifm.forward_a), 32'd0);
        chk("rst_bubble_ex", 32'(ifm.bubble_ex), 32'd0);
        chk("rst_stall_cnt", 32'(ifm.stall_cnt), 32'd0);
        ifm.flush = 0;
        @(negedge clk) rst_n = 1'b1;
        step(alu(3, 1, 2));
        step(alu(5, 3, 4));
        step(alu(6, 1, 3));
        chk("sub_fa_mem", 32'(ifm.forward_a), 32'(FWD_MEM));
        chk("sub_fb_rf", 32'(ifm.forward_b), 32'(FWD_RF));
        step(nop);
        chk("or_fb_wb", 32'(ifm.forward_b), 32'(FWD_WB));
        step(alu(3, 1, 2));
        step(alu(3, 1, 2));
        step(alu(7, 3, 3));
        step(nop);
        chk("prio_fa_mem", 32'(ifm.forward_a), 32'(FWD_MEM));
        chk("prio_fb_mem", 32'(ifm.forward_b), 32'(FWD_MEM));
        step(lw(2, 1));
        step(alu(4, 2, 1));
        chk("lu_stall", 32'(ifm.stall_if_id), 32'd1);
        chk("lu_cnt_before", 32'(ifm.stall_cnt), 32'd0);
        step(alu(4, 2, 1));
        chk("lu_cnt_after", 32'(ifm.stall_cnt), 32'd1);
        step(nop);
        chk("lu_fa_wb", 32'(ifm.forward_a), 32'(FWD_WB));
        step(lw(0, 1));
        step(alu(4, 0, 0));
        chk("r0_no_stall", 32'(ifm.stall_if_id), 32'd0);
        step(nop);
        chk("r0_fa_rf", 32'(ifm.forward_a), 32'(FWD_RF));
        step(lw(2, 1));
        step(alu(4, 2, 1), 1'b1);
        chk("flush_stall", 32'(ifm.stall_if_id), 32'd0);
        chk("flush_bubble", 32'(ifm.bubble_ex), 32'd1);
        step(alu(3, 1, 2));
        chk("flush_cnt", 32'(ifm.stall_cnt), 32'd1);
        step(lw(2, 3));
        for (int k = 0; k < 3; k++) step(alu(4, 2, 1), 1'b0, 1'b1);
        chk("frz_fa", 32'(ifm.forward_a), 32'(FWD_MEM));
        chk("frz_cnt", 32'(ifm.stall_cnt), 32'd1);
        step(alu(4, 2, 1));
        chk("unfrz_stall", 32'(ifm.stall_if_id), 32'd1);
        step(alu(4, 2, 1));
        for (int k = 0; k < 4; k++) begin
            step(lw(2, 1));
            step(alu(4, 1, 2));
            step(alu(4, 1, 2));
        end
        chk("sat_w2", 32'(ifs.stall_cnt), 32'd3);
        chk("sat_w16", 32'(ifm.stall_cnt), 32'd6);
        step(alu(3, 1, 2));
        step(lw(2, 3));
        step(alu(4, 2, 1));
        chk("pre_rst_fa", 32'(ifm.forward_a), 32'(FWD_MEM));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_forward_a", 32'(ifm.forward_a), 32'd0);
        chk("mid_rst_forward_b", 32'(ifm.forward_b), 32'd0);
        chk("mid_rst_stall", 32'(ifm.stall_if_id), 32'd0);
        chk("mid_rst_bubble", 32'(ifm.bubble_ex), 32'd0);
        chk("mid_rst_cnt", 32'(ifm.stall_cnt), 32'd0);
        chk("mid_rst_cnt_w2", 32'(ifs.stall_cnt), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cur = nop;
        last_hold = 1'b0;
        for (int k = 0; k < 200; k++) begin
            logic fl, fz;
            fl = ($urandom_range(0, 9) == 0);
            fz = ($urandom_range(0, 7) == 0);
            if (!last_hold) begin
                case ($urandom_range(0, 2))
                    0: cur = alu(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                    1: cur = lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                    default: cur = nop;
                endcase
            end
            step(cur, fl, fz);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
